// File: rtl/rx_arb_pkg.sv
// rtl/rx_arb_pkg.sv - shared constants and FSM encoding for the RX request arbiter
package rx_arb_pkg;
  localparam int C_RX_TAG_WIDTH = 2;
  localparam int C_ADDR_WIDTH   = 64;
  localparam int C_LEN_WIDTH    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin picker
// Searches upward from ptr+1 (modulo N) for the first eligible requester.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);
  always_comb begin
    int j;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && eligible[j]) begin
        valid    = 1'b1;
        grant[j] = 1'b1;
        idx      = W'(j);
      end
    end
  end
endmodule

// File: rtl/rx_req_arbiter.sv
// rtl/rx_req_arbiter.sv - shares the engine read-request channel between RX channels
// Round-robin grant with per-channel outstanding-read limits and completion tracking.
module rx_req_arbiter
  import rx_arb_pkg::*;
#(
  parameter int C_NUM_CHNL        = 4,
  parameter int C_MAX_OUTSTANDING = 4,
  parameter int C_CHNL_WIDTH      = $clog2(C_NUM_CHNL),
  parameter int C_TAG_WIDTH       = C_CHNL_WIDTH + 2
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic [C_NUM_CHNL-1:0]                CHNL_REQ,
  output logic [C_NUM_CHNL-1:0]                CHNL_REQ_ACK,
  input  logic [C_RX_TAG_WIDTH*C_NUM_CHNL-1:0] CHNL_REQ_TAG,
  input  logic [C_ADDR_WIDTH*C_NUM_CHNL-1:0]   CHNL_REQ_ADDR,
  input  logic [C_LEN_WIDTH*C_NUM_CHNL-1:0]    CHNL_REQ_LEN,
  output logic                                 ENG_REQ,
  input  logic                                 ENG_REQ_ACK,
  output logic [C_TAG_WIDTH-1:0]               ENG_REQ_TAG,
  output logic [C_ADDR_WIDTH-1:0]              ENG_REQ_ADDR,
  output logic [C_LEN_WIDTH-1:0]               ENG_REQ_LEN,
  input  logic                                 ENG_CPL_DONE,
  input  logic [C_TAG_WIDTH-1:0]               ENG_CPL_TAG,
  output logic [C_NUM_CHNL-1:0]                CHNL_BUSY,
  output logic                                 ERR
);
  localparam int            CW      = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(C_MAX_OUTSTANDING);

  arb_state_t                  state_q, state_d;
  logic [CW-1:0]               cnt_q [C_NUM_CHNL];
  logic [CW-1:0]               cnt_d [C_NUM_CHNL];
  logic [C_NUM_CHNL-1:0]       eligible, pick_grant, grant_q, inc_vec, dec_vec;
  logic [C_CHNL_WIDTH-1:0]     pick_idx, ptr_q, winner_q, cpl_chnl;
  logic                        pick_valid, issue_ack, underflow;
  logic [C_RX_TAG_WIDTH-1:0]   unused_cpl_bits;

  assign cpl_chnl        = ENG_CPL_TAG[C_TAG_WIDTH-1:C_RX_TAG_WIDTH];
  assign unused_cpl_bits = ENG_CPL_TAG[C_RX_TAG_WIDTH-1:0];
  assign issue_ack       = (state_q == ISSUE) && ENG_REQ_ACK;
  assign inc_vec         = issue_ack ? grant_q : '0;
  assign dec_vec         = ENG_CPL_DONE ? (C_NUM_CHNL'(1) << cpl_chnl) : '0;

  rr_picker #(.N(C_NUM_CHNL), .W(C_CHNL_WIDTH)) u_picker (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (pick_grant),
    .idx      (pick_idx),
    .valid    (pick_valid)
  );

  // A grant and a completion landing on the same channel cancel out.
  always_comb begin
    underflow = 1'b0;
    eligible  = '0;
    for (int i = 0; i < C_NUM_CHNL; i++) begin
      cnt_d[i]    = cnt_q[i];
      eligible[i] = CHNL_REQ[i] && (cnt_q[i] < CNT_MAX);
      if (inc_vec[i] && !dec_vec[i]) begin
        if (cnt_q[i] != CNT_MAX) cnt_d[i] = cnt_q[i] + CW'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - CW'(1);
        else                underflow = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   if (ENG_REQ_ACK) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ENG_REQ      <= 1'b0;
      ENG_REQ_TAG  <= '0;
      ENG_REQ_ADDR <= '0;
      ENG_REQ_LEN  <= '0;
      CHNL_REQ_ACK <= '0;
      CHNL_BUSY    <= '0;
      ERR          <= 1'b0;
      grant_q      <= '0;
      winner_q     <= '0;
      ptr_q        <= C_CHNL_WIDTH'(C_NUM_CHNL - 1);
      for (int i = 0; i < C_NUM_CHNL; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_CHNL; i++) begin
        cnt_q[i]     <= cnt_d[i];
        CHNL_BUSY[i] <= (cnt_d[i] != '0);
      end
      if (underflow) ERR <= 1'b1;
      case (state_q)
        IDLE: if (pick_valid) begin
          ENG_REQ      <= 1'b1;
          grant_q      <= pick_grant;
          winner_q     <= pick_idx;
          ENG_REQ_TAG  <= {pick_idx, CHNL_REQ_TAG[C_RX_TAG_WIDTH*int'(pick_idx) +: C_RX_TAG_WIDTH]};
          ENG_REQ_ADDR <= CHNL_REQ_ADDR[C_ADDR_WIDTH*int'(pick_idx) +: C_ADDR_WIDTH];
          ENG_REQ_LEN  <= CHNL_REQ_LEN[C_LEN_WIDTH*int'(pick_idx) +: C_LEN_WIDTH];
        end
        ISSUE: if (ENG_REQ_ACK) begin
          ENG_REQ      <= 1'b0;
          CHNL_REQ_ACK <= grant_q;
          ptr_q        <= winner_q;
        end
        ACK:     CHNL_REQ_ACK <= '0;
        default: CHNL_REQ_ACK <= '0;
      endcase
    end
  end
endmodule
